x_uart_rx: RTL and testbench

UART receiver for the 8N1 serial link: oversamples the asynchronous `i_rx` pin with the system clock, recovers start, 8 data bits (LSB first) and stop, and presents each byte on a valid/ready handshake. It sits at the pin side of the host link, opposite the design's UART transmitter, and uses the same baud-timer arithmetic so both ends agree on bit period.

---
 rtl/x_uart_rx.sv | 154 +++++++++++++++
 tb/tb_x_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized pin, mid-bit sampling, valid/ready byte output.
// Define X_UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around mid-bit.
module x_uart_rx #(
    parameter int unsigned p_clk_hz = 12000000,
    parameter int unsigned p_baud   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned TOP = p_clk_hz / p_baud;
    localparam int unsigned MID = TOP / 2;
    // Width must be able to hold TOP itself, which matters when TOP is a power of two.
    localparam int unsigned TW  = $clog2(TOP + 1);

    localparam logic [TW-1:0] TOP_T = TW'(TOP);
    localparam logic [TW-1:0] MID_T = TW'(MID);

    if (TOP < 8) begin : g_top_check
        $error("x_uart_rx: p_clk_hz / p_baud must be at least 8");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_START,
        S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7,
        S_STOP, S_WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_meta_q, rx_s_q;
    logic          sample_en;
    logic          sample_bit;

`ifdef X_UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] MID_M1 = TW'(MID - 1);
    localparam logic [TW-1:0] MID_P1 = TW'(MID + 1);
    logic [1:0] maj_q, maj_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~i_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

`ifdef X_UART_RX_MAJORITY_EN
        maj_d = maj_q;
        if (timer_q == MID_M1) maj_d[0] = rx_s_q;
        if (timer_q == MID_T)  maj_d[1] = rx_s_q;
        sample_en  = (timer_q == MID_P1);
        sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);
`else
        sample_en  = (timer_q == MID_T);
        sample_bit = rx_s_q;
`endif

        if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
            timer_d = '0;
        end else begin
            timer_d = (timer_q == TOP_T) ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (sample_en && sample_bit) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == TOP_T) begin
                    state_d = S_D0;
                end
            end
            S_STOP: begin
                if (sample_en) begin
                    timer_d = '0;
                    if (sample_bit) begin
                        state_d = S_IDLE;
                        // Acceptance in this same cycle frees the holding register.
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                // Data states: shifting right leaves the first-received bit in bit 0.
                if (sample_en) shift_d = {sample_bit, shift_q[7:1]};
                if (timer_q == TOP_T) state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef X_UART_RX_MAJORITY_EN
            maj_q     <= '1;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef X_UART_RX_MAJORITY_EN
            maj_q     <= maj_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_x_uart_rx.sv
// Bench for x_uart_rx: directed and random 8N1 frames against a frame-level byte/event model.
module tb_x_uart_rx;

    localparam int unsigned CLK_HZ = 12000000;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned TOP    = CLK_HZ / BAUD;
    localparam int unsigned BIT    = TOP + 1;
    localparam int unsigned MID    = TOP / 2;
`ifdef X_UART_RX_MAJORITY_EN
    localparam int unsigned DECIDE     = MID + 1;
    localparam logic [7:0]  GLITCH_EXP = 8'h00;
`else
    localparam int unsigned DECIDE     = MID;
    localparam logic [7:0]  GLITCH_EXP = 8'h04;
`endif
    // Pin edge to o_valid: 2 sync + 1 detect, 9 bit periods, decision cycle, register.
    localparam int unsigned LAT        = 3 + 9 * BIT + DECIDE + 1;
    // Pin cycle whose value rx_s presents while the timer sits at MID in D2.
    localparam int          GLITCH_CYC = 1 + 3 * BIT + MID;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    x_uart_rx #(.p_clk_hz(CLK_HZ), .p_baud(BAUD)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: records handshakes, valid rise times and pulse cycles.
    int unsigned cyc = 0;
    logic [7:0]  got_q[$];
    int unsigned rise_q[$];
    int unsigned ferr_cnt = 0, ovr_cnt = 0, valid_cnt = 0;
    logic        prev_valid = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_valid && i_ready) got_q.push_back(o_data);
        if (o_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid <= o_valid;
        if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (o_overrun) ovr_cnt <= ovr_cnt + 1;
        if (o_valid) valid_cnt <= valid_cnt + 1;
    end

    // Reference model: expected delivered bytes and event totals.
    logic [7:0]  exp_q[$];
    int unsigned exp_ferr = 0, exp_ovr = 0, exp_rises = 0, verified = 0;
    logic        held = 1'b0;
    logic [7:0]  held_byte = '0;
    int unsigned n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int unsigned ncyc,
                               input int glitch);
        logic [9:0] fb;
        fb = {stop, d, 1'b0};
        for (int c = 0; c < int'(ncyc); c++) begin
            i_rx = fb[c / BIT] ^ logic'(c == glitch);
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (!stop) begin
            exp_ferr++;
        end else if (held && !i_ready) begin
            exp_ovr++;
        end else if (i_ready) begin
            exp_q.push_back(d);
            exp_rises++;
        end else begin
            held      = 1'b1;
            held_byte = d;
            exp_rises++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive_frame(d, stop, 10 * BIT, -1);
        model_frame(d, stop);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int unsigned i = verified; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        verified = exp_q.size();
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
        check({tag, "_rises"}, rise_q.size(), exp_rises);
    endtask

    initial begin
        int unsigned t0, vc0, n_good;
        logic [7:0]  d;
        logic        stop;

        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        i_ready = 1'b0;
        idle(3);
        check("rst_data", o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        check("rst_ovr", o_overrun, 1'b0);
        i_rst_n = 1'b1;
        idle(5);

        // Basic frames with permanent ready, plus start-to-valid latency.
        i_ready = 1'b1;
        vc0 = valid_cnt;
        t0  = cyc;
        send(8'h55, 1'b1);
        send(8'hA5, 1'b1);
        idle(5);
        compare_all("basic");
        check("latency", (rise_q.size() > 0) ? rise_q[0] - t0 : 0, LAT);
        check("basic_valid_cycles", valid_cnt - vc0, 2);

        // False start.
        i_rx = 1'b0;
        idle(20);
        i_rx = 1'b1;
        idle(2 * BIT);
        compare_all("false_start");
        send(8'h3C, 1'b1);
        idle(5);
        compare_all("after_false");

        // Frame error followed by a break.
        send(8'h81, 1'b0);
        i_rx = 1'b0;
        idle(3 * BIT);
        i_rx = 1'b1;
        idle(10);
        compare_all("frame_err");
        send(8'h42, 1'b1);
        idle(5);
        compare_all("after_ferr");

        // Overrun while the consumer stalls.
        i_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        idle(5);
        check("ovr_valid_held", o_valid, 1'b1);
        check("ovr_data_held", o_data, 8'h11);
        compare_all("overrun");
        i_ready = 1'b1;
        exp_q.push_back(held_byte);
        held = 1'b0;
        idle(1);
        check("ovr_valid_drop", o_valid, 1'b0);
        compare_all("ovr_accept");

        // Reset in D3 with a byte held.
        i_ready = 1'b0;
        send(8'h99, 1'b1);
        drive_frame(8'hF0, 1'b1, 4 * BIT + 50, -1);
        i_rx    = 1'b1;
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_data", o_data, 8'h00);
        held = 1'b0;
        idle(2);
        i_rst_n = 1'b1;
        idle(5);
        i_ready = 1'b1;
        send(8'h0F, 1'b1);
        idle(5);
        compare_all("after_reset");

        // Single-cycle high glitch at mid-bit of D2.
        drive_frame(8'h00, 1'b1, 10 * BIT, GLITCH_CYC);
        exp_q.push_back(GLITCH_EXP);
        exp_rises++;
        idle(5);
        compare_all("glitch");

        // Random bytes, occasional bad stop bits, random idle gaps.
        vc0    = valid_cnt;
        n_good = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if (stop) n_good++;
            send(d, stop);
            i_rx = 1'b1;
            idle($urandom_range(3, 40));
        end
        compare_all("random");
        check("random_valid_cycles", valid_cnt - vc0, n_good);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
